mux_stream_sel: RTL and testbench

- Parametrised, registered CH:1 stream multiplexer; successor to the fixed 64:1 single-bit combinational mux trees in the multiplexor lab set.
- Generalised in channel count and data width.
- Adds a per-channel valid/ready handshake, a registered output slot with backpressure, and three selection modes: direct, scan and round-robin.
- Sits between CH independent producers and one consumer.

---
 rtl/mux_stream_pkg.sv | 29 ++
 rtl/rr_pick.sv | 64 ++++++
 rtl/mux_stream_sel.sv | 171 +++++++++++++++++
 tb/tb_mux_stream_sel.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_pkg
//  Description : Shared types and helpers for the stream multiplexer family.
//                - mode_t   : selection mode encoding carried on the mode port
//                - next_idx : circular increment of a channel index in 0..ch-1
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_stream_pkg;

    // Encoding matches the two-bit mode port: 00 direct, 01 scan,
    // 10 round-robin, 11 hold.
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SCAN   = 2'b01,
        MODE_RR     = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_t;

    // Circular increment. The explicit compare against ch-1 keeps the index
    // inside 0..ch-1 when ch is not a power of two, where a plain binary
    // rollover would visit indices that do not exist.
    function automatic int unsigned next_idx(input int unsigned idx,
                                             input int unsigned ch);
        return (idx == ch - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin pick. Returns the first asserted request found
//                searching circularly upward from base (base included).
//  Ports       : req   [CH]    request vector
//                base  [SEL_W] index where the search starts (0..CH-1)
//                grant [SEL_W] index of the first request at or after base
//                any           at least one request asserted
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter  int CH    = 64,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic [CH-1:0]    req,
    input  logic [SEL_W-1:0] base,
    output logic [SEL_W-1:0] grant,
    output logic             any
);

    // One extra index bit covers the doubled vector (0..2*CH-1).
    localparam int IW = SEL_W + 1;
    localparam logic [IW-1:0] c_CH = IW'(CH);

    logic [CH-1:0]   w_mask;
    logic [2*CH-1:0] w_dbl;
    logic [IW-1:0]   w_first;
    logic [IW-1:0]   w_off;

    // Mask off requests below base in the lower copy only. A plain lowest-bit
    // priority encoder over {req, req & mask} then finds the first request at
    // or above base, falling through to the unmasked upper copy to wrap.
    generate
        for (genvar i = 0; i < CH; i++) begin : g_mask
            assign w_mask[i] = (SEL_W'(i) >= base);
        end
    endgenerate

    assign w_dbl = {req, req & w_mask};

    // Descending scan: the last hit written is the lowest set bit.
    always_comb begin
        w_first = '0;
        for (int i = 2 * CH - 1; i >= 0; i--) begin
            if (w_dbl[i]) begin
                w_first = IW'(i);
            end
        end
    end

    // Fold an upper-copy position back onto the real channel index.
    always_comb begin
        w_off = w_first;
        if (w_first >= c_CH) begin
            w_off = w_first - c_CH;
        end
    end

    assign grant = w_off[SEL_W-1:0];
    assign any   = |req;

endmodule
`default_nettype wire

// File: rtl/mux_stream_sel.sv
`default_nettype none
// ============================================================================
//  Module      : mux_stream_sel
//  Description : Registered CH:1 stream multiplexer with per-channel
//                valid/ready handshake, single output slot with backpressure
//                and direct / scan / round-robin / hold channel selection.
//  Ports       : clk                  rising-edge clock
//                rst                  synchronous active-high reset
//                in_data   [CH*DW]    channel i at bits [i*DW +: DW]
//                in_valid  [CH]       per-channel valid
//                in_ready  [CH]       per-channel ready, one-hot or zero
//                mode      [2]        00 direct, 01 scan, 10 rr, 11 hold
//                sel       [SEL_W]    channel index for direct mode
//                out_data  [DW]       registered selected data
//                out_ch    [SEL_W]    channel that supplied out_data
//                out_valid            output slot full
//                out_ready            consumer ready
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_stream_sel
    import mux_stream_pkg::*;
#(
    parameter  int CH    = 64,
    parameter  int DW    = 8,
    localparam int SEL_W = $clog2(CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH*DW-1:0]    in_data,
    input  logic [CH-1:0]       in_valid,
    output logic [CH-1:0]       in_ready,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [DW-1:0]       out_data,
    output logic [SEL_W-1:0]    out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    localparam logic [SEL_W-1:0] c_LAST = SEL_W'(CH - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DW-1:0]    r_out_data;
    logic [SEL_W-1:0] r_out_ch;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    // ------------------------------------------------------------------
    // Combinational pick
    // ------------------------------------------------------------------
    mode_t            w_mode;
    logic [DW-1:0]    w_ch_data [CH];
    logic [SEL_W-1:0] w_rr_grant;
    logic             w_rr_any;
    logic [SEL_W-1:0] w_chosen;
    logic             w_hit;
    logic             w_load_en;
    logic             w_accept;
    logic [CH-1:0]    w_in_ready;
    logic [SEL_W-1:0] w_ptr_inc;
    logic [SEL_W-1:0] w_grant_inc;

    assign w_mode = mode_t'(mode);

    generate
        for (genvar i = 0; i < CH; i++) begin : g_unpack
            assign w_ch_data[i] = in_data[i*DW +: DW];
        end
    endgenerate

    rr_pick #(
        .CH    (CH)
    ) u_rr_pick (
        .req   (in_valid),
        .base  (r_ptr),
        .grant (w_rr_grant),
        .any   (w_rr_any)
    );

    always_comb begin
        w_chosen = '0;
        w_hit    = 1'b0;
        case (w_mode)
            MODE_DIRECT: begin
                w_chosen = sel;
                // sel can name a channel that does not exist when CH is not
                // a power of two; such a request never hits.
                w_hit    = (sel <= c_LAST) && in_valid[sel];
            end
            MODE_SCAN: begin
                w_chosen = r_ptr;
                w_hit    = in_valid[r_ptr];
            end
            MODE_RR: begin
                w_chosen = w_rr_grant;
                w_hit    = w_rr_any;
            end
            default: begin
                w_chosen = '0;
                w_hit    = 1'b0;
            end
        endcase
    end

    // The slot can take a word when empty or when its word leaves this cycle,
    // which gives back-to-back transfers without a bubble.
    assign w_load_en = !r_out_valid || out_ready;

    // rst gates the handshake so no producer sees a transfer that the reset
    // is about to discard.
    assign w_accept  = w_load_en && w_hit && !rst;

    always_comb begin
        w_in_ready = '0;
        if (w_accept) begin
            w_in_ready[w_chosen] = 1'b1;
        end
    end

    assign in_ready = w_in_ready;

    assign w_ptr_inc   = SEL_W'(next_idx(32'(r_ptr), CH));
    assign w_grant_inc = SEL_W'(next_idx(32'(w_chosen), CH));

    // ------------------------------------------------------------------
    // Output slot and pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_accept) begin
                r_out_data  <= w_ch_data[w_chosen];
                r_out_ch    <= w_chosen;
                r_out_valid <= 1'b1;
            end else begin
                // Data and channel keep their last values; only the slot
                // empties.
                r_out_valid <= 1'b0;
            end

            // Scan advances on every opportunity, valid channel or not.
            // Round-robin moves past the granted channel so it gets the
            // lowest priority next time.
            case (w_mode)
                MODE_SCAN: begin
                    r_ptr <= w_ptr_inc;
                end
                MODE_RR: begin
                    if (w_accept) begin
                        r_ptr <= w_grant_inc;
                    end
                end
                default: begin
                    r_ptr <= r_ptr;
                end
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_sel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_stream_sel
//  Description : Self-checking bench for mux_stream_sel. Two instances run
//                side by side: CH=8 (power of two) and CH=6 (non power of
//                two), both DW=8. A behavioural model of the slot, pointer
//                and channel pick predicts in_ready and the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_stream_sel;

    logic clk;
    logic rst;

    // Stimulus per instance (index 0: CH=8, index 1: CH=6)
    logic [7:0] tv    [2];
    logic [7:0] td    [2][8];
    logic [1:0] tmode [2];
    logic [2:0] tsel  [2];
    logic       tor   [2];

    logic [63:0] in_data8;
    logic [7:0]  in_ready8;
    logic [7:0]  out_data8;
    logic [2:0]  out_ch8;
    logic        out_valid8;

    logic [47:0] in_data6;
    logic [5:0]  in_ready6;
    logic [7:0]  out_data6;
    logic [2:0]  out_ch6;
    logic        out_valid6;

    generate
        for (genvar g = 0; g < 8; g++) begin : g_d8
            assign in_data8[g*8 +: 8] = td[0][g];
        end
        for (genvar g = 0; g < 6; g++) begin : g_d6
            assign in_data6[g*8 +: 8] = td[1][g];
        end
    endgenerate

    mux_stream_sel #(.CH(8), .DW(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data8),
        .in_valid  (tv[0]),
        .in_ready  (in_ready8),
        .mode      (tmode[0]),
        .sel       (tsel[0]),
        .out_data  (out_data8),
        .out_ch    (out_ch8),
        .out_valid (out_valid8),
        .out_ready (tor[0])
    );

    mux_stream_sel #(.CH(6), .DW(8)) u_dut6 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data6),
        .in_valid  (tv[1][5:0]),
        .in_ready  (in_ready6),
        .mode      (tmode[1]),
        .sel       (tsel[1]),
        .out_data  (out_data6),
        .out_ch    (out_ch6),
        .out_valid (out_valid6),
        .out_ready (tor[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int   chn [2] = '{8, 6};
    bit   m_valid [2];
    logic [7:0] m_data [2];
    int   m_ch  [2];
    int   m_ptr [2];

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string tag, input int d,
                       input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Which channel the rules select, and whether it has data.
    task automatic pick(input int d, output bit hit, output int cho);
        int n;
        n   = chn[d];
        hit = 1'b0;
        cho = 0;
        case (tmode[d])
            2'd0: begin
                cho = int'(tsel[d]);
                hit = (cho < n) && tv[d][cho];
            end
            2'd1: begin
                cho = m_ptr[d];
                hit = tv[d][cho];
            end
            2'd2: begin
                for (int k = 0; k < n; k++) begin
                    if (!hit && tv[d][(m_ptr[d] + k) % n]) begin
                        hit = 1'b1;
                        cho = (m_ptr[d] + k) % n;
                    end
                end
            end
            default: hit = 1'b0;
        endcase
    endtask

    // One clock: check in_ready mid-cycle, advance model, check outputs.
    task automatic tick();
        bit   hit;
        int   cho;
        bit   acc [2];
        int   chs [2];
        bit   lds [2];
        logic [7:0] er;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            pick(d, hit, cho);
            lds[d] = !m_valid[d] || tor[d];
            acc[d] = lds[d] && hit && !rst;
            chs[d] = cho;
            er = acc[d] ? 8'(1 << cho) : 8'h00;
            chk("in_ready", d, (d == 0) ? {24'b0, in_ready8} : {26'b0, in_ready6},
                {24'b0, er});
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_valid[d] = 1'b0;
                m_data[d]  = 8'h00;
                m_ch[d]    = 0;
                m_ptr[d]   = 0;
            end else if (lds[d]) begin
                if (acc[d]) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = td[d][chs[d]];
                    m_ch[d]    = chs[d];
                end else begin
                    m_valid[d] = 1'b0;
                end
                if (tmode[d] == 2'd1) begin
                    m_ptr[d] = (m_ptr[d] + 1) % chn[d];
                end else if (tmode[d] == 2'd2 && acc[d]) begin
                    m_ptr[d] = (chs[d] + 1) % chn[d];
                end
            end
        end
        #1;
        chk("out_valid", 0, {31'b0, out_valid8}, {31'b0, m_valid[0]});
        chk("out_data",  0, {24'b0, out_data8},  {24'b0, m_data[0]});
        chk("out_ch",    0, {29'b0, out_ch8},    32'(m_ch[0]));
        chk("out_valid", 1, {31'b0, out_valid6}, {31'b0, m_valid[1]});
        chk("out_data",  1, {24'b0, out_data6},  {24'b0, m_data[1]});
        chk("out_ch",    1, {29'b0, out_ch6},    32'(m_ch[1]));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = 8'h00;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
            tmode[d]   = 2'd1;
            tsel[d]    = 3'd0;
            tor[d]     = 1'b1;
            for (int i = 0; i < 8; i++) td[d][i] = 8'($urandom);
        end
        tv[0] = 8'hFF;
        tv[1] = 8'h3F;

        // Reset held two cycles with every channel valid.
        rst = 1'b1;
        tick();
        tick();

        // Release in scan: first accepted channel is 0.
        rst = 1'b0;
        tick();
        chk("first_scan_ch", 0, {29'b0, out_ch8}, 32'd0);

        // Direct mode, sel=5.
        tmode[0] = 2'd0;
        tsel[0]  = 3'd5;
        tv[0]    = 8'h20;
        td[0][5] = 8'hA5;
        tick();
        chk("direct_data", 0, {24'b0, out_data8}, 32'h0000_00A5);
        tick();

        // Backpressure: slot held, ch5 changes ignored.
        tor[0] = 1'b0;
        repeat (3) begin
            td[0][5] = 8'($urandom);
            tick();
        end
        tor[0] = 1'b1;
        tick();

        // Scan on CH=6 from a freshly reset pointer, d0 parked in hold.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tmode[0] = 2'd3;
        tmode[1] = 2'd1;
        tv[1]    = 8'h2A;
        repeat (13) tick();

        // Round-robin on CH=8: 0,7,0,7 then full rotation.
        tmode[0] = 2'd2;
        tv[0]    = 8'h81;
        repeat (4) tick();
        tv[0] = 8'hFF;
        repeat (10) tick();

        // Reset mid-stream with the slot full, then lowest valid wins.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tv[0] = 8'h0C;
        tick();
        chk("rr_after_reset", 0, {29'b0, out_ch8}, 32'd2);

        // Direct sel beyond CH-1 on the CH=6 instance never hits.
        tmode[1] = 2'd0;
        tsel[1]  = 3'd7;
        tv[1]    = 8'h3F;
        tick();
        tick();

        // Randomised traffic; modes change occasionally so scan and
        // round-robin run long enough to wrap.
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 7) == 0) tmode[d] = 2'($urandom_range(0, 3));
                tsel[d] = 3'($urandom_range(0, 7));
                tv[d]   = 8'($urandom) & ((d == 0) ? 8'hFF : 8'h3F);
                tor[d]  = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 8; i++) td[d][i] = 8'($urandom);
            end
            rst = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
